// File: rtl/jb_clk_en_pkg.sv
// Shared types, constants and period decode for the clock-enable monitor.
package jb_clk_en_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED
   } clk_en_mon_state_t;

   localparam int unsigned MAX_PERIOD     = 16;
   localparam int unsigned GAP_W          = 5;
   localparam logic [2:0]  RATIO_UNLOCKED = 3'd7;

   // Power-of-two periods up to MAX_PERIOD map to log2; anything else is unlocked.
   function automatic logic [2:0] period_to_ratio(input logic [GAP_W-1:0] period);
      logic [2:0] w_ratio;
      case (period)
         5'd1:    w_ratio = 3'd0;
         5'd2:    w_ratio = 3'd1;
         5'd4:    w_ratio = 3'd2;
         5'd8:    w_ratio = 3'd3;
         5'd16:   w_ratio = 3'd4;
         default: w_ratio = RATIO_UNLOCKED;
      endcase
      return w_ratio;
   endfunction

endpackage

// File: rtl/jb_clk_en_period_meas.sv
// Gap counter between enable strobes: reports the measured period on each strobe,
// whether it is a legal divide ratio, and a timeout once the gap saturates.
module jb_clk_en_period_meas
   import jb_clk_en_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en_in,
   output logic             period_valid,
   output logic [GAP_W-1:0] period,
   output logic             period_legal,
   output logic             timeout_flag
);

   localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(MAX_PERIOD + 1);

   logic [GAP_W-1:0] r_gap;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_gap <= '0;
      end else if (clk_en_in) begin
         r_gap <= GAP_W'(1);
      end else if (r_gap != GAP_SAT) begin
         r_gap <= r_gap + GAP_W'(1);
      end
   end

   assign period_valid = clk_en_in;
   assign period       = r_gap;
   assign period_legal = (period_to_ratio(r_gap) != RATIO_UNLOCKED);
   // A strobe in the saturation cycle wins over the timeout.
   assign timeout_flag = (r_gap == GAP_SAT) && !clk_en_in;

endmodule

// File: rtl/jb_clk_en_mon.sv
// Clock-enable monitor: locks onto a legal strobe period and flags loss of lock.
// Optional saturating error counter enabled by JB_CLK_EN_MON_ERR_CNT_EN.
module jb_clk_en_mon
   import jb_clk_en_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk_en_in,
   output logic       locked,
   output logic [2:0] ratio_code,
   output logic       err_pulse,
   output logic [7:0] err_count
);

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

   logic             w_pvalid;
   logic [GAP_W-1:0] w_period;
   logic             w_legal;
   logic             w_timeout;

   clk_en_mon_state_t r_state, w_state_d;
   logic [GAP_W-1:0]  r_cand, w_cand_d;
   logic [3:0]        r_match, w_match_d, w_match_nxt;
   logic              w_err_d;
   logic              r_locked;
   logic [2:0]        r_ratio;
   logic              r_err;

   jb_clk_en_period_meas u_meas (
      .clk          (clk),
      .reset        (reset),
      .clk_en_in    (clk_en_in),
      .period_valid (w_pvalid),
      .period       (w_period),
      .period_legal (w_legal),
      .timeout_flag (w_timeout)
   );

   always_comb begin
      w_state_d   = r_state;
      w_cand_d    = r_cand;
      w_match_d   = r_match;
      w_err_d     = 1'b0;
      w_match_nxt = (w_period == r_cand) ? (r_match + 4'd1) : 4'd1;
      unique case (r_state)
         IDLE: begin
            if (w_pvalid) begin
               w_state_d = MEASURE;
               w_cand_d  = '0;
               w_match_d = '0;
            end
         end
         MEASURE: begin
            if (w_pvalid && w_legal) begin
               w_cand_d  = w_period;
               w_match_d = w_match_nxt;
               if (w_match_nxt == LOCK_CNT) w_state_d = LOCKED;
            end else if (w_pvalid) begin
               w_cand_d  = '0;
               w_match_d = '0;
            end else if (w_timeout) begin
               w_state_d = IDLE;
            end
         end
         LOCKED: begin
            // Wrong period: the offending strobe restarts timing from scratch.
            if (w_pvalid && (w_period != r_cand)) begin
               w_err_d   = 1'b1;
               w_state_d = MEASURE;
               w_cand_d  = '0;
               w_match_d = '0;
            end else if (!w_pvalid && (w_period == r_cand)) begin
               w_err_d   = 1'b1;
               w_state_d = IDLE;
               w_cand_d  = '0;
               w_match_d = '0;
            end
         end
         default: begin
            w_state_d = IDLE;
            w_cand_d  = '0;
            w_match_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cand   <= '0;
         r_match  <= '0;
         r_locked <= 1'b0;
         r_ratio  <= RATIO_UNLOCKED;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_cand   <= w_cand_d;
         r_match  <= w_match_d;
         r_locked <= (w_state_d == LOCKED);
         r_ratio  <= (w_state_d == LOCKED) ? period_to_ratio(w_cand_d) : RATIO_UNLOCKED;
         r_err    <= w_err_d;
      end
   end

   assign locked     = r_locked;
   assign ratio_code = r_ratio;
   assign err_pulse  = r_err;

`ifdef JB_CLK_EN_MON_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err_cnt <= '0;
      end else if (w_err_d && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign err_count = r_err_cnt;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_jb_clk_en_mon.sv
// Scoreboard bench for jb_clk_en_mon: a timestamp-based reference model predicts
// each cycle's outputs, a monitor compares them against the DUT.
module tb_jb_clk_en_mon;

   localparam int unsigned LOCK_COUNT = 4;
   localparam int M_IDLE = 0;
   localparam int M_MEAS = 1;
   localparam int M_LOCK = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clk_en_in = 1'b0;
   logic       locked;
   logic [2:0] ratio_code;
   logic       err_pulse;
   logic [7:0] err_count;

   always #5 clk = ~clk;

   jb_clk_en_mon #(
      .LOCK_COUNT (LOCK_COUNT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en_in  (clk_en_in),
      .locked     (locked),
      .ratio_code (ratio_code),
      .err_pulse  (err_pulse),
      .err_count  (err_count)
   );

   typedef struct packed {
      logic       locked;
      logic [2:0] ratio;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass = 0;

   // Reference model state: mode, cycle of the last strobe, locked/candidate period.
   int m_mode = M_IDLE;
   int m_last = 0;
   int m_cand = 0;
   int m_runs = 0;
   int m_errs = 0;
   int m_cyc  = 0;

   function automatic bit is_legal(input int p);
      return (p == 1) || (p == 2) || (p == 4) || (p == 8) || (p == 16);
   endfunction

   task automatic model_step(input bit rst, input bit s);
      exp_t e;
      bit   err;
      int   el;
      err = 1'b0;
      el  = m_cyc - m_last;
      if (rst) begin
         m_mode = M_IDLE;
         m_errs = 0;
         m_cand = 0;
         m_runs = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (s) begin
                  m_mode = M_MEAS;
                  m_cand = 0;
                  m_runs = 0;
                  m_last = m_cyc;
               end
            end
            M_MEAS: begin
               if (s) begin
                  if (is_legal(el)) begin
                     if (el == m_cand) m_runs++;
                     else begin
                        m_cand = el;
                        m_runs = 1;
                     end
                     if (m_runs == LOCK_COUNT) m_mode = M_LOCK;
                  end else begin
                     m_cand = 0;
                     m_runs = 0;
                  end
                  m_last = m_cyc;
               end else if (el >= 17) begin
                  m_mode = M_IDLE;
               end
            end
            default: begin
               if (s) begin
                  if (el != m_cand) begin
                     err    = 1'b1;
                     m_mode = M_MEAS;
                     m_cand = 0;
                     m_runs = 0;
                  end
                  m_last = m_cyc;
               end else if (el == m_cand) begin
                  err    = 1'b1;
                  m_mode = M_IDLE;
               end
            end
         endcase
`ifdef JB_CLK_EN_MON_ERR_CNT_EN
         if (err && (m_errs < 255)) m_errs++;
`endif
      end
      e.locked = (m_mode == M_LOCK);
      e.ratio  = e.locked ? 3'($clog2(m_cand)) : 3'd7;
      e.err    = err;
      e.cnt    = 8'(m_errs);
      sb_q.push_back(e);
      m_cyc++;
   endtask

   task automatic drive(input bit rst, input bit s);
      @(negedge clk);
      reset     = rst;
      clk_en_in = s;
      model_step(rst, s);
   endtask

   // n strobes, each preceded by period-1 quiet cycles.
   task automatic pulse_train(input int period, input int n);
      for (int i = 0; i < n; i++) begin
         repeat (period - 1) drive(1'b0, 1'b0);
         drive(1'b0, 1'b1);
      end
   endtask

   task automatic quiet(input int n);
      repeat (n) drive(1'b0, 1'b0);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check("locked", int'(locked), int'(mon_e.locked));
         check("ratio_code", int'(ratio_code), int'(mon_e.ratio));
         check("err_pulse", int'(err_pulse), int'(mon_e.err));
         check("err_count", int'(err_count), int'(mon_e.cnt));
      end
   end

   int per_tab[9] = '{1, 2, 4, 8, 16, 3, 5, 12, 20};

   initial begin
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      // Div4 lock.
      drive(1'b0, 1'b1);
      pulse_train(4, 6);
      // Div8 lock, then a period-4 strobe, then relock at div4.
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      pulse_train(8, 5);
      pulse_train(4, 1);
      pulse_train(4, 5);
      // Div2 lock, then strobes stop.
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      pulse_train(2, 5);
      quiet(30);
      // Illegal period 3 for ~100 cycles.
      drive(1'b0, 1'b1);
      pulse_train(3, 33);
      quiet(20);
      // Div1: strobe held high.
      drive(1'b1, 1'b0);
      pulse_train(1, 12);
      // Div16 lock, then reset while locked.
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      pulse_train(16, 5);
      quiet(5);
      drive(1'b1, 1'b0);
      quiet(4);
      // 300 forced errors: lock at div1, drop one strobe.
      for (int i = 0; i < 300; i++) begin
         pulse_train(1, 5);
         drive(1'b0, 1'b0);
      end
      // Random period mix with occasional resets.
      drive(1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) drive(1'b1, 1'($urandom_range(0, 1)));
         pulse_train(per_tab[$urandom_range(0, 8)], int'($urandom_range(1, 6)));
      end
      quiet(20);
      @(posedge clk);
      #2;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
